hazard_unit_sb: RTL and testbench



---
 rtl/hazard_unit_sb_pkg.sv | 16 +
 rtl/sb_timer.sv | 23 ++
 rtl/hazard_unit_sb.sv | 108 ++++++++++
 tb/tb_hazard_unit_sb.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_sb_pkg.sv
// Shared pipeline constants: branch opcodes and default result latencies,
// so that decode and the hazard unit agree on timing.
package hazard_unit_sb_pkg;

    localparam logic [3:0] OP_B  = 4'b1100;
    localparam logic [3:0] OP_BR = 4'b1101;

    localparam int DEF_NUM_REGS  = 16;
    localparam int DEF_REG_W     = 4;
    localparam int DEF_ALU_LAT   = 2;
    localparam int DEF_LOAD_LAT  = 3;
    localparam int DEF_FWD_GAP   = 2;
    localparam int DEF_FLAG_LAT  = 1;
    localparam int DEF_MAX_STALL = 15;

endpackage

// File: rtl/sb_timer.sv
// Saturating down-counter with synchronous load; one per tracked register
// and one for the flags.
module sb_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/hazard_unit_sb.sv
// Scoreboard hazard unit beside ID: per-register and flag countdown timers
// decide stalls; a consecutive-stall counter drives a sticky watchdog error.
module hazard_unit_sb
    import hazard_unit_sb_pkg::*;
#(
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int REG_W     = DEF_REG_W,
    parameter int ALU_LAT   = DEF_ALU_LAT,
    parameter int LOAD_LAT  = DEF_LOAD_LAT,
    parameter int FWD_GAP   = DEF_FWD_GAP,
    parameter int FLAG_LAT  = DEF_FLAG_LAT,
    parameter int MAX_STALL = DEF_MAX_STALL
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           id_valid,
    input  logic                           id_flush,
    input  logic [REG_W-1:0]               id_rs,
    input  logic [REG_W-1:0]               id_rt,
    input  logic                           id_rs_used,
    input  logic                           id_rt_used,
    input  logic                           id_br_reg,
    input  logic                           id_flag_use,
    input  logic                           id_wr_en,
    input  logic [REG_W-1:0]               id_rd,
    input  logic                           id_is_load,
    input  logic                           id_sets_flag,
    output logic                           pc_write_en,
    output logic                           ifid_write_en,
    output logic                           control_mux,
    output logic                           stall,
    output logic [$clog2(MAX_STALL+1)-1:0] stall_cnt,
    output logic                           hazard_err
);

    localparam int CNT_W  = $clog2(LOAD_LAT + 1);
    localparam int FLAG_W = (FLAG_LAT < 2) ? 1 : $clog2(FLAG_LAT + 1);
    localparam int SC_W   = $clog2(MAX_STALL + 1);

    localparam logic [CNT_W-1:0]  ALU_V  = CNT_W'(ALU_LAT);
    localparam logic [CNT_W-1:0]  LOAD_V = CNT_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0]  FWD_V  = CNT_W'(FWD_GAP);
    localparam logic [FLAG_W-1:0] FLAG_V = FLAG_W'(FLAG_LAT);
    localparam logic [SC_W-1:0]   MAX_V  = SC_W'(MAX_STALL);

    logic [CNT_W-1:0]  cnt [NUM_REGS];
    logic [FLAG_W-1:0] flag_cnt;
    logic              live;
    logic              issue;

    // r0 is hardwired zero: its timer is a constant so reads of r0 never stall.
    assign cnt[0] = '0;

    generate
        for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
            logic ld;
            assign ld = issue && id_wr_en && (id_rd == REG_W'(r));
            sb_timer #(.W(CNT_W)) u_timer (
                .clk      (clk),
                .rst      (rst),
                .load     (ld),
                .load_val (id_is_load ? LOAD_V : ALU_V),
                .count    (cnt[r])
            );
        end
    endgenerate

    sb_timer #(.W(FLAG_W)) u_flag_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (issue && id_sets_flag),
        .load_val (FLAG_V),
        .count    (flag_cnt)
    );

    // EX-stage consumers tolerate up to FWD_GAP via forwarding; BR reads rs in ID
    // so it needs the timer fully expired.
    always_comb begin
        live  = id_valid && !id_flush;
        stall = live && (
                    (id_rs_used && (id_rs != '0) && (cnt[id_rs] > FWD_V)) ||
                    (id_rt_used && (id_rt != '0) && (cnt[id_rt] > FWD_V)) ||
                    (id_br_reg  && (id_rs != '0) && (cnt[id_rs] != '0))   ||
                    (id_flag_use && (flag_cnt != '0)));
        issue         = live && !stall;
        pc_write_en   = !stall;
        ifid_write_en = !stall;
        control_mux   = !stall;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt  <= '0;
            hazard_err <= 1'b0;
        end else begin
            if (stall) begin
                if (stall_cnt == MAX_V) begin
                    hazard_err <= 1'b1;
                end else begin
                    stall_cnt <= stall_cnt + 1'b1;
                end
            end else begin
                stall_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Directed and randomised hazard sequences; expected stall vectors are queued
// as each ID instruction is driven and compared against the DUT outputs.
module tb_hazard_unit_sb;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_flush;
    logic [3:0] id_rs, id_rt, id_rd;
    logic       id_rs_used, id_rt_used, id_br_reg, id_flag_use;
    logic       id_wr_en, id_is_load, id_sets_flag;
    logic       pc_write_en, ifid_write_en, control_mux, stall;
    logic [3:0] stall_cnt;
    logic       hazard_err;

    int         n_vec = 0;
    int         n_bad = 0;
    logic [8:0] exp_q[$];
    logic [3:0] exp_sc;
    logic       exp_err;

    hazard_unit_sb dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_flush      (id_flush),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rs_used    (id_rs_used),
        .id_rt_used    (id_rt_used),
        .id_br_reg     (id_br_reg),
        .id_flag_use   (id_flag_use),
        .id_wr_en      (id_wr_en),
        .id_rd         (id_rd),
        .id_is_load    (id_is_load),
        .id_sets_flag  (id_sets_flag),
        .pc_write_en   (pc_write_en),
        .ifid_write_en (ifid_write_en),
        .control_mux   (control_mux),
        .stall         (stall),
        .stall_cnt     (stall_cnt),
        .hazard_err    (hazard_err)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got stall/pc/ifid/mux/cnt/err=%b expected %b", tag, obs, exp);
        end
    endtask

    // Queue the expected outputs for the instruction now in ID, advance the
    // expected stall counter, then sample just after inputs settle.
    task automatic step(input string tag, input logic s);
        logic [8:0] e;
        exp_q.push_back({s, !s, !s, !s, exp_sc, exp_err});
        if (s) begin
            if (exp_sc == 4'd15) exp_err = 1'b1;
            else                 exp_sc  = exp_sc + 4'd1;
        end else begin
            exp_sc = 4'd0;
        end
        #1;
        e = exp_q.pop_front();
        check_vec(tag, {stall, pc_write_en, ifid_write_en, control_mux, stall_cnt, hazard_err}, e);
        @(negedge clk);
    endtask

    task automatic idle();
        id_valid = 0; id_flush = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_rs_used = 0; id_rt_used = 0; id_br_reg = 0; id_flag_use = 0;
        id_wr_en = 0; id_is_load = 0; id_sets_flag = 0;
    endtask

    task automatic nop();
        idle(); id_valid = 1;
    endtask

    task automatic alu(input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt);
        nop(); id_rs = rs; id_rt = rt; id_rs_used = 1; id_rt_used = 1;
        id_wr_en = 1; id_rd = rd;
    endtask

    task automatic lw(input logic [3:0] rd, input logic [3:0] rs);
        nop(); id_rs = rs; id_rs_used = 1; id_wr_en = 1; id_rd = rd; id_is_load = 1;
    endtask

    task automatic br(input logic [3:0] rs);
        nop(); id_rs = rs; id_br_reg = 1; id_flag_use = 1;
    endtask

    task automatic b_op();
        nop(); id_flag_use = 1;
    endtask

    task automatic setf();
        nop(); id_sets_flag = 1;
    endtask

    task automatic drain();
        nop();
        for (int i = 0; i < 4; i++) step("drain", 0);
    endtask

    initial begin
        logic [3:0] r;
        exp_sc = 0; exp_err = 0;
        rst = 1; idle();
        @(negedge clk);
        step("reset", 0);
        lw(4'd3, 4'd0);
        step("reset_lw", 0);
        rst = 0;

        // load -> use: one bubble
        lw(4'd3, 4'd1);  step("lw_r3", 0);
        alu(4'd9, 4'd3, 4'd2); step("ld_use_stall", 1); step("ld_use_issue", 0);
        drain();

        // ALU -> BR: two bubbles; load -> BR: three
        alu(4'd5, 4'd1, 4'd2); step("alu_r5", 0);
        br(4'd5); step("alu_br_s1", 1); step("alu_br_s2", 1); step("alu_br_go", 0);
        drain();
        lw(4'd5, 4'd1); step("lw_r5", 0);
        br(4'd5); step("ld_br_s1", 1); step("ld_br_s2", 1); step("ld_br_s3", 1); step("ld_br_go", 0);
        drain();

        // flag setter -> B: one bubble; a NOP between hides it
        setf(); step("setf", 0);
        b_op(); step("flag_b_stall", 1); step("flag_b_go", 0);
        drain();
        setf(); step("setf2", 0);
        nop();  step("nop_gap", 0);
        b_op(); step("flag_b_gap", 0);
        drain();

        // ALU -> ALU forwards without a stall
        alu(4'd8, 4'd1, 4'd2); step("alu_r8", 0);
        alu(4'd10, 4'd8, 4'd8); step("alu_alu", 0);
        drain();

        // r0 is never tracked
        lw(4'd0, 4'd1); step("lw_r0", 0);
        alu(4'd11, 4'd0, 4'd0); step("use_r0", 0);
        br(4'd0); step("br_r0", 0);
        drain();

        // flushed load never arms its timer
        lw(4'd4, 4'd1); id_flush = 1; step("lw_r4_flush", 0);
        alu(4'd11, 4'd4, 4'd4); step("use_r4", 0);
        drain();

        // flush masks a live hazard; the timer keeps counting regardless
        lw(4'd6, 4'd1); step("lw_r6", 0);
        br(4'd6); id_flush = 1; step("br_flush", 0);
        br(4'd6); step("br_r6_s1", 1); step("br_r6_s2", 1); step("br_r6_go", 0);
        drain();

        // newer, shorter ALU write overwrites the load timer
        lw(4'd7, 4'd1); step("lw_r7", 0);
        alu(4'd7, 4'd1, 4'd2); step("alu_r7", 0);
        br(4'd7); step("ovw_s1", 1); step("ovw_s2", 1); step("ovw_go", 0);
        drain();

        // randomised load-use on arbitrary registers
        for (int k = 0; k < 4; k++) begin
            r = 4'($urandom_range(1, 15));
            lw(r, 4'd0); step("rnd_lw", 0);
            alu(4'd0, 4'd0, r); step("rnd_stall", 1); step("rnd_go", 0);
            drain();
        end

        // watchdog: hold a flag hazard permanently
        force dut.flag_cnt = 1'b1;
        b_op();
        for (int i = 0; i < 18; i++) step("wdog", 1);
        release dut.flag_cnt;
        nop();
        for (int i = 0; i < 3; i++) step("err_sticky", 0);
        b_op(); step("wdog_clear", 0);

        // asynchronous reset mid-stall
        lw(4'd9, 4'd1); step("lw_r9", 0);
        br(4'd9); step("br_r9_s1", 1);
        #2;
        rst = 1; exp_sc = 0; exp_err = 0;
        step("async_rst", 0);
        rst = 0;
        br(4'd9); step("post_rst_br", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
